// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: MIPS fetch stage with a DEPTH-entry prefetch queue in front of a variable-latency instruction memory
// Ports: PFU_CLK/PFU_RST clock and async active-low reset; PFU_PcSrc/PFU_PcBranch/PFU_PcJump redirect control;
// PFU_StallF decode back-pressure; PFU_MemReq/PFU_MemAddr/PFU_MemGnt request handshake; PFU_MemRspValid/PFU_MemRspData
// in-order responses; PFU_Instr/PFU_PcPlus4/PFU_Valid head of queue; PFU_Count allocated entries.
module prefetch_fetch_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     PFU_CLK,
    input  logic                     PFU_RST,
    input  logic [1:0]               PFU_PcSrc,
    input  logic [WIDTH-1:0]         PFU_PcBranch,
    input  logic [WIDTH-1:0]         PFU_PcJump,
    input  logic                     PFU_StallF,
    output logic                     PFU_MemReq,
    output logic [WIDTH-1:0]         PFU_MemAddr,
    input  logic                     PFU_MemGnt,
    input  logic                     PFU_MemRspValid,
    input  logic [WIDTH-1:0]         PFU_MemRspData,
    output logic [WIDTH-1:0]         PFU_Instr,
    output logic [WIDTH-1:0]         PFU_PcPlus4,
    output logic                     PFU_Valid,
    output logic [$clog2(DEPTH):0]   PFU_Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic [WIDTH-1:0] pc4_q [DEPTH];
    logic [WIDTH-1:0] pc4_d [DEPTH];
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
    logic [CW-1:0]    count_q, count_d, dc_q, dc_d, pend_q, pend_d;
    logic             redirect, gnt, pop, rsp_take, rsp_drop;
    // pend_q counts allocated-but-unfilled slots; fptr_q points at the oldest of them
    assign redirect    = PFU_PcSrc == 2'b01 || PFU_PcSrc == 2'b10;
    assign PFU_MemReq  = PFU_RST && count_q < CW'(DEPTH) && !redirect;
    assign PFU_MemAddr = fpc_q;
    assign gnt         = PFU_MemReq && PFU_MemGnt;
    assign PFU_Valid   = count_q != '0 && filled_q[head_q];
    assign PFU_Instr   = PFU_Valid ? instr_q[head_q] : '0;
    assign PFU_PcPlus4 = PFU_Valid ? pc4_q[head_q] : '0;
    assign PFU_Count   = count_q;
    assign pop         = PFU_Valid && !PFU_StallF && !redirect;
    assign rsp_drop    = PFU_MemRspValid && dc_q != '0;
    assign rsp_take    = PFU_MemRspValid && dc_q == '0 && pend_q != '0;
    always_comb begin
        fpc_d    = fpc_q;
        pc4_d    = pc4_q;
        instr_d  = instr_q;
        filled_d = filled_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        head_d   = head_q + PW'(pop);
        count_d  = count_q + CW'(gnt) - CW'(pop);
        pend_d   = pend_q + CW'(gnt) - CW'(rsp_take);
        dc_d     = dc_q - CW'(rsp_drop);
        if (redirect) begin
            fpc_d    = PFU_PcSrc[0] ? PFU_PcBranch : PFU_PcJump;
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fptr_d   = '0;
            count_d  = '0;
            pend_d   = '0;
            // every unfilled fetch becomes a discard, less a response consumed this very cycle
            dc_d     = dc_q + pend_q - CW'(rsp_take || rsp_drop);
        end else begin
            if (gnt) begin
                pc4_d[tail_q]    = fpc_q + WIDTH'(4);
                filled_d[tail_q] = 1'b0;
                fpc_d            = fpc_q + WIDTH'(4);
                tail_d           = tail_q + PW'(1);
            end
            if (rsp_take) begin
                instr_d[fptr_q]  = PFU_MemRspData;
                filled_d[fptr_q] = 1'b1;
                fptr_d           = fptr_q + PW'(1);
            end
        end
    end
    always_ff @(posedge PFU_CLK or negedge PFU_RST) begin
        if (!PFU_RST) begin
            fpc_q    <= RESET_PC;
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            count_q  <= '0;
            dc_q     <= '0;
            pend_q   <= '0;
        end else begin
            fpc_q    <= fpc_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fptr_q   <= fptr_d;
            count_q  <= count_d;
            dc_q     <= dc_d;
            pend_q   <= pend_d;
        end
    end
    // slot payloads are qualified by filled_q and count_q, so they need no reset
    always_ff @(posedge PFU_CLK) begin
        pc4_q   <= pc4_d;
        instr_q <= instr_d;
    end
endmodule
